// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
// Used by inst_fetch and, when IFETCH_PERF_CNT_EN is defined, by inst_fetch_perf.
package ifetch_pkg;

    localparam int unsigned PC_W           = 32;
    localparam int unsigned DEF_IMEM_DEPTH = 256;
    localparam logic [PC_W-1:0] DEF_RESET_PC = '0;

    typedef enum logic [1:0] {
        FS_PRIME = 2'd0,
        FS_RUN   = 2'd1,
        FS_STALL = 2'd2,
        FS_REDIR = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_perf.sv
// Wrapping event counters for the fetch stage; only instantiated when
// IFETCH_PERF_CNT_EN is defined.
module inst_fetch_perf
    import ifetch_pkg::*;
(
    input  logic            clock,
    input  logic            reset_n,
    input  logic            transfer,
    input  logic            stall,
    input  logic            redirect,
    output logic [PC_W-1:0] perf_fetched,
    output logic [PC_W-1:0] perf_stalls,
    output logic [PC_W-1:0] perf_redirects
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched   <= '0;
            perf_stalls    <= '0;
            perf_redirects <= '0;
        end else begin
            if (transfer) perf_fetched   <= perf_fetched + 1'b1;
            if (stall)    perf_stalls    <= perf_stalls + 1'b1;
            if (redirect) perf_redirects <= perf_redirects + 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Single-slot instruction fetch stage with stall and branch redirect.
// Optional counters are added when IFETCH_PERF_CNT_EN is defined.
//
// state    | meaning
// FS_PRIME | first cycle after reset, memory data not yet valid
// FS_RUN   | fetching one instruction per cycle
// FS_STALL | decode busy, slot and pc held
// FS_REDIR | pc just redirected, capture the target instruction
module inst_fetch
    import ifetch_pkg::*;
#(
    parameter int unsigned      IMEM_DEPTH = DEF_IMEM_DEPTH,
    parameter logic [PC_W-1:0]  RESET_PC   = DEF_RESET_PC
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic            id_ready,
    output logic [PC_W-1:0] imem_addr,
    input  logic [PC_W-1:0] imem_inst,
    output logic            if_valid,
    output logic [PC_W-1:0] if_inst,
    output logic [PC_W-1:0] if_pc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [PC_W-1:0] perf_fetched,
    output logic [PC_W-1:0] perf_stalls,
    output logic [PC_W-1:0] perf_redirects
`endif
);

    localparam logic [PC_W-1:0] PC_MASK = PC_W'(IMEM_DEPTH - 1);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_d;
    logic [PC_W-1:0] inst_d, slot_pc_d;
    logic            capture;

    assign imem_addr = pc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        valid_d   = if_valid;
        inst_d    = if_inst;
        slot_pc_d = if_pc;
        capture   = 1'b0;
        if (branch_taken) begin
            // Redirect beats everything, including a held stalled instruction.
            state_d = FS_REDIR;
            pc_d    = branch_target & PC_MASK;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                FS_PRIME: state_d = FS_RUN;
                FS_REDIR: begin
                    capture = 1'b1;
                    state_d = FS_RUN;
                end
                FS_RUN: begin
                    if (!if_valid || id_ready) capture = 1'b1;
                    else                       state_d = FS_STALL;
                end
                FS_STALL: begin
                    if (id_ready) begin
                        capture = 1'b1;
                        state_d = FS_RUN;
                    end
                end
                default: state_d = FS_PRIME;
            endcase
            if (capture) begin
                inst_d    = imem_inst;
                slot_pc_d = pc_q;
                valid_d   = 1'b1;
                pc_d      = (pc_q + 1'b1) & PC_MASK;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FS_PRIME;
            pc_q     <= RESET_PC & PC_MASK;
            if_valid <= 1'b0;
            if_inst  <= '0;
            if_pc    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            if_valid <= valid_d;
            if_inst  <= inst_d;
            if_pc    <= slot_pc_d;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    inst_fetch_perf u_perf (
        .clock          (clock),
        .reset_n        (reset_n),
        .transfer       (if_valid && id_ready),
        .stall          (state_q == FS_STALL),
        .redirect       (branch_taken),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
        .perf_redirects (perf_redirects)
    );
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed vector bench for inst_fetch; perf counter checks compile in
// only when IFETCH_PERF_CNT_EN is defined.
module tb_inst_fetch;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stalls, perf_redirects;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];

    inst_fetch dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .id_ready      (id_ready),
        .imem_addr     (imem_addr),
        .imem_inst     (imem_inst),
        .if_valid      (if_valid),
        .if_inst       (if_inst),
        .if_pc         (if_pc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls),
        .perf_redirects (perf_redirects)
`endif
    );

    always #5 clock = ~clock;

    // Memory samples the address on the falling edge.
    always @(negedge clock) imem_inst = mem[imem_addr[7:0]];

    typedef struct {
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
        logic [31:0] eaddr;
    } vec_t;

    vec_t vecs [25];

    function automatic vec_t mk(logic br, logic [31:0] tgt, logic rdy, logic ev,
                                logic [31:0] epc, logic [31:0] einst, logic [31:0] eaddr);
        vec_t v;
        v.br = br; v.tgt = tgt; v.rdy = rdy; v.ev = ev;
        v.epc = epc; v.einst = einst; v.eaddr = eaddr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic br, input logic [31:0] tgt, input logic rdy);
        branch_taken  = br;
        branch_target = tgt;
        id_ready      = rdy;
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h100 + i;
        branch_taken = 1'b0; branch_target = '0; id_ready = 1'b1;

        // Post-reset priming, then streaming
        vecs[0]  = mk(0, 0,      1, 0, 0,      0,      0);
        vecs[1]  = mk(0, 0,      1, 1, 0,      32'h100, 1);
        vecs[2]  = mk(0, 0,      1, 1, 1,      32'h101, 2);
        vecs[3]  = mk(0, 0,      1, 1, 2,      32'h102, 3);
        // Three-cycle stall holding if_pc=2
        vecs[4]  = mk(0, 0,      0, 1, 2,      32'h102, 3);
        vecs[5]  = mk(0, 0,      0, 1, 2,      32'h102, 3);
        vecs[6]  = mk(0, 0,      0, 1, 2,      32'h102, 3);
        vecs[7]  = mk(0, 0,      1, 1, 3,      32'h103, 4);
        vecs[8]  = mk(0, 0,      1, 1, 4,      32'h104, 5);
        // Branch to 10 while pc_q=5
        vecs[9]  = mk(1, 10,     1, 0, 0,      0,      10);
        vecs[10] = mk(0, 0,      1, 1, 10,     32'h10A, 11);
        vecs[11] = mk(0, 0,      1, 1, 11,     32'h10B, 12);
        // Branch during stall; target captured regardless of id_ready
        vecs[12] = mk(0, 0,      0, 1, 11,     32'h10B, 12);
        vecs[13] = mk(0, 0,      0, 1, 11,     32'h10B, 12);
        vecs[14] = mk(1, 20,     0, 0, 0,      0,      20);
        vecs[15] = mk(0, 0,      0, 1, 20,     32'h114, 21);
        vecs[16] = mk(0, 0,      0, 1, 20,     32'h114, 21);
        vecs[17] = mk(0, 0,      1, 1, 21,     32'h115, 22);
        // Out-of-range target wraps, then pc wraps at depth
        vecs[18] = mk(1, 32'h1FE, 1, 0, 0,     0,      32'hFE);
        vecs[19] = mk(0, 0,      1, 1, 32'hFE, 32'h1FE, 32'hFF);
        vecs[20] = mk(0, 0,      1, 1, 32'hFF, 32'h1FF, 0);
        vecs[21] = mk(0, 0,      1, 1, 0,      32'h100, 1);
        // Branch during FS_REDIR
        vecs[22] = mk(1, 3,      1, 0, 0,      0,      3);
        vecs[23] = mk(1, 7,      1, 0, 0,      0,      7);
        vecs[24] = mk(0, 0,      0, 1, 7,      32'h107, 8);

        #1 reset_n = 1'b0;
        #1;
        check("reset if_valid", {31'd0, if_valid}, 32'd0);
        check("reset if_pc", if_pc, 32'd0);
        check("reset if_inst", if_inst, 32'd0);
        check("reset imem_addr", imem_addr, 32'd0);
        #10 reset_n = 1'b1;

        for (int i = 0; i < 25; i++) begin
            cyc(vecs[i].br, vecs[i].tgt, vecs[i].rdy);
            check($sformatf("v%0d if_valid", i), {31'd0, if_valid}, {31'd0, vecs[i].ev});
            check($sformatf("v%0d imem_addr", i), imem_addr, vecs[i].eaddr);
            if (vecs[i].ev) begin
                check($sformatf("v%0d if_pc", i), if_pc, vecs[i].epc);
                check($sformatf("v%0d if_inst", i), if_inst, vecs[i].einst);
            end
        end

        // Asynchronous reset between edges mid-run
        cyc(0, 0, 1);
        #3 reset_n = 1'b0;
        #1;
        check("mid reset if_valid", {31'd0, if_valid}, 32'd0);
        check("mid reset if_pc", if_pc, 32'd0);
        check("mid reset if_inst", if_inst, 32'd0);
        check("mid reset imem_addr", imem_addr, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("mid reset perf_fetched", perf_fetched, 32'd0);
        check("mid reset perf_stalls", perf_stalls, 32'd0);
        check("mid reset perf_redirects", perf_redirects, 32'd0);
`endif
        #2 reset_n = 1'b1;
        cyc(0, 0, 1);
        check("reprime if_valid", {31'd0, if_valid}, 32'd0);
        cyc(0, 0, 1);
        check("restart if_valid", {31'd0, if_valid}, 32'd1);
        check("restart if_inst", if_inst, 32'h100);
        // Three more transfers, two stall cycles, then a branch with a transfer
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 0, 1);
        check("post stall if_pc", if_pc, 32'd4);
        cyc(1, 9, 1);
        cyc(0, 0, 0);
        check("redir if_pc", if_pc, 32'd9);
`ifdef IFETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, 32'd5);
        check("perf_stalls", perf_stalls, 32'd2);
        check("perf_redirects", perf_redirects, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: IMEM_DEPTH, 256, instruction memory depth in words; SHALL be a power of two.
REQ-002 Parameter: RESET_PC, 0, first fetch address after reset.
REQ-003 Port: clock  in  1  single clock; all state SHALL be updated on posedge only.
REQ-004 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-005 Port: branch_taken  in  1  redirect request from execute.
REQ-006 Port: branch_target  in  32  redirect word address.
REQ-007 Port: id_ready  in  1  decode can accept an instruction this cycle.
REQ-008 Port: imem_addr  out  32  word address to the instruction memory, driven directly from pc_q.
REQ-009 Port: imem_inst  in  32  memory data; the memory samples imem_addr on negedge, so data SHALL be treated as valid at the following posedge.
REQ-010 Port: if_valid  out  1  IF/ID slot holds an instruction.
REQ-011 Port: if_inst  out  32  fetched instruction.
REQ-012 Port: if_pc  out  32  word address of if_inst.

Function
REQ-013 States SHALL be FS_PRIME, FS_RUN, FS_STALL, FS_REDIR.
REQ-014 Transfer to decode SHALL occur on a posedge where if_valid=1 and id_ready=1.
REQ-015 Capture means: if_inst<=imem_inst, if_pc<=pc_q, if_valid<=1, pc_q<=next(pc_q).
REQ-016 next(p) SHALL be p+1, wrapping from IMEM_DEPTH-1 to 0; imem_addr bits above log2(IMEM_DEPTH) SHALL be 0.
REQ-017 branch_taken=1 SHALL win over all other conditions in every state: pc_q<=branch_target mod IMEM_DEPTH, if_valid<=0, state<=FS_REDIR, and the slot contents are discarded, including a stalled instruction.
REQ-018 FS_PRIME: no capture; next state FS_RUN. This covers the missing negedge after reset release.
REQ-019 FS_REDIR: capture (target instruction); next state FS_RUN. A redirect therefore costs exactly one bubble cycle.
REQ-020 FS_RUN: if if_valid=0 or id_ready=1, capture and stay in FS_RUN; otherwise hold all outputs and pc_q, and go to FS_STALL.
REQ-021 FS_STALL: hold if_*, pc_q and imem_addr while id_ready=0; on id_ready=1, capture and go to FS_RUN.
REQ-022 imem_addr SHALL be stable for the whole cycle, because it is registered, with no combinational path from any input.
REQ-023 Steady-state throughput SHALL be one instruction per cycle; fetch-to-if_valid latency SHALL be one cycle.

Reset
REQ-024 reset_n=0 SHALL immediately, without a clock edge, set pc_q=RESET_PC, if_valid=0, if_inst=0, if_pc=0 and state=FS_PRIME; the same SHALL apply mid-operation.

Configuration
REQ-025 When IFETCH_PERF_CNT_EN is defined, the block SHALL add outputs perf_fetched, perf_stalls and perf_redirects (32 bits each, reset to 0, wrapping). These count transfers, FS_STALL cycles and taken branches respectively.
REQ-026 When IFETCH_PERF_CNT_EN is undefined, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package ifetch_pkg SHALL hold the fetch-state enum, the default IMEM_DEPTH and RESET_PC constants, and the PC width constant.
REQ-028 The counters SHALL live in sub-module inst_fetch_perf, instantiated only under IFETCH_PERF_CNT_EN.

Verification
REQ-029 Scenario: release reset with id_ready=1 and mem[i]=0x100+i. Required: if_valid=0 on the first edge, then if_pc 0,1,2,... with if_inst 0x100,0x101,0x102 on consecutive cycles.
REQ-030 Scenario: id_ready=0 for 3 cycles while if_pc=2. Required: if_pc=2, if_inst=0x102 and imem_addr=3 held; after id_ready=1 the next is if_pc=3.
REQ-031 Scenario: branch_taken with target 10 while pc_q=5. Required: exactly one cycle if_valid=0, then if_pc=10, if_inst=0x10A; address 5 is never presented.
REQ-032 Scenario: branch during FS_STALL. Required: the held instruction is dropped and the target is presented after one bubble, regardless of id_ready.
REQ-033 Scenario: branch target 0x1FE. Required: if_pc sequence 0xFE, 0xFF, 0x00.
REQ-034 Scenario: reset_n low between edges mid-run. Required: outputs zero immediately. With IFETCH_PERF_CNT_EN, 5 transfers, 2 stall cycles and 1 branch give perf counters 5, 2, 1.
